// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-aligned value updates.
// Segment and select outputs are registered from the post-edge scan state.
module seg_scan_ctrl #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [15:0] Value,
    input  logic        Load,
    input  logic        BlankLZ,
    output logic [7:0]  Segments,
    output logic [3:0]  DigitSel,
    output logic        LoadAck
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    typedef enum logic {StIdle, StScan} state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  k_q, k_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] pend_val_q, pend_val_d;
    logic        pend_q, pend_d;
    logic        apply;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  sel_q, sel_d;
    logic        ack_q, ack_d;
    logic [15:0] upper;

    function automatic logic [7:0] decode7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            4'hF: s = 8'h71;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            k_q        <= 2'd3;
            shadow_q   <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            seg_q      <= '0;
            sel_q      <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            shadow_q   <= shadow_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            seg_q      <= seg_d;
            sel_q      <= sel_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        shadow_d   = shadow_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        apply      = 1'b0;
        unique case (state_q)
            StIdle: begin
                apply = 1'b1;
                cnt_d = '0;
                k_d   = 2'd3;
                if (Enable) state_d = StScan;
            end
            StScan: begin
                // Dropping Enable skips the frame-end apply; IDLE applies on the next edge.
                if (!Enable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    k_d     = 2'd3;
                end else if (cnt_q == LAST) begin
                    cnt_d = '0;
                    k_d   = k_q - 2'd1;
                    apply = (k_q == 2'd0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
        if (Load) begin
            pend_val_d = Value;
            pend_d     = 1'b1;
        end
        if (apply) begin
            if (Load)        shadow_d = Value;
            else if (pend_q) shadow_d = pend_val_q;
            pend_d = 1'b0;
        end
        ack_d = apply && (Load || pend_q);
    end

    // Upper holds Shadow[15:4k], so leading-zero blanking is a simple zero test.
    always_comb begin
        upper = shadow_d >> {k_d, 2'b00};
        seg_d = '0;
        sel_d = '0;
        if (state_d == StScan) begin
            sel_d = 4'b0001 << k_d;
            if (!(BlankLZ && (k_d != 2'd0) && (upper == 16'h0000))) begin
                seg_d = decode7(upper[3:0]);
            end
        end
    end

    assign Segments = seg_q;
    assign DigitSel = sel_q;
    assign LoadAck  = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position reference model checked every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_seg_scan_ctrl;

    localparam int unsigned P = 4;
    localparam int FRAME = 4 * P;

    logic        Clk = 1'b0;
    logic        Reset, Enable, Load, BlankLZ;
    logic [15:0] Value;
    logic [7:0]  Segments;
    logic [3:0]  DigitSel;
    logic        LoadAck;

    int total = 0;
    int bad = 0;

    // Reference model: scan tracked as a position within the frame.
    bit          m_scan;
    int          m_pos;
    logic [15:0] m_shadow, m_pval;
    bit          m_pend;
    logic [7:0]  e_seg;
    logic [3:0]  e_sel;
    logic        e_ack;
    logic [7:0]  seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    seg_scan_ctrl #(.PRESCALE(P)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Enable   (Enable),
        .Value    (Value),
        .Load     (Load),
        .BlankLZ  (BlankLZ),
        .Segments (Segments),
        .DigitSel (DigitSel),
        .LoadAck  (LoadAck)
    );

    initial forever #5 Clk = ~Clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit          apply;
        logic [15:0] sh;
        logic [15:0] up;
        int          d;
        if (Reset) begin
            m_scan = 0; m_pos = 0; m_shadow = '0; m_pval = '0; m_pend = 0;
            e_seg = '0; e_sel = '0; e_ack = 1'b0;
        end else begin
            apply = !m_scan || (Enable && m_pos == FRAME - 1);
            e_ack = apply && (Load || m_pend);
            sh = m_shadow;
            if (apply) begin
                if (Load)        sh = Value;
                else if (m_pend) sh = m_pval;
            end
            if (Load) begin
                m_pval = Value;
                m_pend = 1;
            end
            if (apply) m_pend = 0;
            m_shadow = sh;
            if (!Enable) begin
                m_scan = 0; m_pos = 0;
            end else if (!m_scan) begin
                m_scan = 1; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
            end
            if (m_scan) begin
                d = 3 - m_pos / P;
                up = m_shadow >> (4 * d);
                e_sel = 4'(1 << d);
                e_seg = (BlankLZ && d != 0 && up == 16'h0) ? 8'h00 : seg_tab[up[3:0]];
            end else begin
                e_sel = '0;
                e_seg = '0;
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input bit ld, input logic [15:0] val,
                       input bit blz);
        Reset = rst; Enable = en; Load = ld; Value = val; BlankLZ = blz;
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check("model_seg", 16'(Segments), 16'(e_seg));
        check("model_sel", 16'(DigitSel), 16'(e_sel));
        check("model_ack", 16'(LoadAck), 16'(e_ack));
    endtask

    // One full frame with Enable held; segs packs {digit3,digit2,digit1,digit0}.
    task automatic run_frame(input string tag, input logic [31:0] segs, input bit blz,
                             input bit first_ack, input int la, input logic [15:0] lv,
                             input int lb, input logic [15:0] lw);
        for (int i = 0; i < FRAME; i++) begin
            bit          ld;
            logic [15:0] v;
            ld = (i == la) || (i == lb);
            v  = (i == lb) ? lw : lv;
            cyc(0, 1, ld, v, blz);
            check({tag, "_sel"}, 16'(DigitSel), 16'(4'b1000 >> (i / P)));
            check({tag, "_seg"}, 16'(Segments), 16'(segs[31 - 8 * (i / P) -: 8]));
            check({tag, "_ack"}, 16'(LoadAck), 16'((i == 0) && first_ack));
        end
    endtask

    initial begin
        bit blz_r;
        Reset = 1; Enable = 0; Load = 0; Value = '0; BlankLZ = 0;
        cyc(1, 0, 0, 16'h0, 0);
        cyc(1, 1, 1, 16'hFFFF, 0);
        check("rst_seg", 16'(Segments), 16'h0);
        check("rst_sel", 16'(DigitSel), 16'h0);
        check("rst_ack", 16'(LoadAck), 16'h0);
        cyc(0, 0, 0, 16'h0, 0);
        check("idle_sel", 16'(DigitSel), 16'h0);

        run_frame("f_003d", 32'h3F3F4F5E, 0, 1, 0, 16'h003D, -1, 16'h0);
        run_frame("f_blank", 32'h00004F5E, 1, 0, -1, 16'h0, -1, 16'h0);
        cyc(0, 0, 0, 16'h0, 0);
        check("drop_sel", 16'(DigitSel), 16'h0);
        check("drop_seg", 16'(Segments), 16'h0);
        run_frame("f_1234", 32'h065B4F66, 0, 1, 0, 16'h1234, 4, 16'hABCD);
        run_frame("f_abcd", 32'h777C395E, 0, 1, 2, 16'h1111, 9, 16'h2222);
        run_frame("f_2222", 32'h5B5B5B5B, 0, 1, -1, 16'h0, -1, 16'h0);
        run_frame("f_bypass", 32'h713F3F3F, 0, 1, 0, 16'hF000, -1, 16'h0);

        for (int i = 0; i < 6; i++) cyc(0, 1, i == 2, 16'h5555, 0);
        cyc(1, 1, 0, 16'h0, 0);
        check("midrst_seg", 16'(Segments), 16'h0);
        check("midrst_sel", 16'(DigitSel), 16'h0);
        check("midrst_ack", 16'(LoadAck), 16'h0);
        run_frame("f_after_rst", 32'h3F3F3F3F, 0, 0, -1, 16'h0, -1, 16'h0);

        blz_r = 0;
        for (int n = 0; n < 3000; n++) begin
            bit          rst, en, ld;
            logic [15:0] v;
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 15) != 0);
            ld  = ($urandom_range(0, 7) == 0);
            v   = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 63) == 0) blz_r = !blz_r;
            cyc(rst, en, ld, v, blz_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
